pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and taken branches resolved from EX/MEM outputs.
- Freezes the pipeline while data memory is not ready.
- Flags memory timeouts and counts stall cycles for performance debug.

Parameters:
REG_W, 5, register-address width.
WAIT_MAX, 8, maximum wait_cnt value in MEM_WAIT before the timeout error.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
id_rs  in  REG_W  rs field of the instruction in ID.
id_rt  in  REG_W  rt field of the instruction in ID.
idex_mem_read  in  1  ID/EX control: instruction in EX is a load.
idex_rt  in  REG_W  ID/EX destination rt of that load.
exmem_branch  in  1  EX/MEM control: branch instruction in MEM.
exmem_zero  in  1  EX/MEM registered ALU zero flag.
dmem_req  in  1  MEM-stage instruction accesses data memory.
dmem_ready  in  1  data memory completes the access this cycle.
pc_en  out  1  PC load enable.
pc_src  out  1  1 = PC takes branch target (EX/MEM add result).
ifid_en, idex_en, exmem_en  out  1 each  pipeline-register load enables.
ifid_flush, idex_flush, exmem_flush  out  1 each  register loads zeros (bubble); overrides the matching enable.
memwb_en  out  1  MEM/WB load enable.
memwb_bubble  out  1  MEM/WB loads a bubble.
state  out  2  FSM state.
timeout_err  out  1  sticky memory-timeout flag.
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Internal terms:
  - load_use = idex_mem_read & idex_rt!=0 & (idex_rt==id_rs | idex_rt==id_rt).
  - br_taken = exmem_branch & exmem_zero.
  - mem_wait = dmem_req & ~dmem_ready.
- States: RUN=0, MEM_WAIT=1, ERROR=2. Outputs are combinational from state, inputs and reset.
- Default outputs: all enables 1, all flushes and bubble 0, pc_src 0.
- RUN decisions, in priority order:
  1. mem_wait: pc_en, ifid_en, idex_en and exmem_en are 0. memwb_en=1, memwb_bubble=1. Next state is MEM_WAIT; wait_cnt<=1.
  2. br_taken: pc_src=1, pc_en=1. ifid_flush, idex_flush and exmem_flush are 1. Next state RUN. Branch penalty is 3 cycles.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1. Next state RUN. This gives exactly one stall cycle, because the load leaves EX next cycle.
  4. Otherwise: default outputs.
- MEM_WAIT:
  - dmem_ready=1: outputs are identical to RUN with mem_wait=0 (branch/load-use still evaluated). Next state RUN; wait_cnt<=0.
  - dmem_ready=0 and wait_cnt<WAIT_MAX: hold outputs as RUN case 1; wait_cnt<=wait_cnt+1.
  - dmem_ready=0 and wait_cnt==WAIT_MAX: outputs as case 1. Next state ERROR; timeout_err<=1.
- ERROR: all enables 0, memwb_bubble=0, flushes 0. The state is left only by reset.
- stall_cnt increments every non-reset cycle with pc_en=0 in RUN or MEM_WAIT. It saturates at all-ones and does not count in ERROR.
- dmem_req dropping while in MEM_WAIT is treated as dmem_ready=1.
- Reset (reset=0 at posedge): state<=RUN, wait_cnt<=0, stall_cnt<=0, timeout_err<=0.
  - While reset=0, outputs are forced: enables 0; ifid/idex/exmem flush 1; memwb_bubble 1; pc_src 0.
  - Reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge.

Decomposition:
- Shared package holds:
  - state encoding (RUN/MEM_WAIT/ERROR);
  - REG_W and CNT_W defaults;
  - the WAIT_MAX default.
- One combinational sub-module, hazard_detect, produces load_use and br_taken. The FSM, counters and output decode stay in pipeline_hazard_ctrl.

Test Plan:
- Load-use: idex_mem_read=1, idex_rt=5, id_rs=5, one cycle. Expect pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cnt=1. Repeat with idex_rt=0: no stall.
- Branch: exmem_branch=1, exmem_zero=1. Expect pc_src=1 and ifid/idex/exmem flush=1 for one cycle. With exmem_zero=0: defaults.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready. Expect state MEM_WAIT for 3 cycles, then RUN; memwb_bubble=1 for 3 cycles; stall_cnt=3.
- Priority: mem_wait, br_taken and load_use all set in RUN. Expect memory freeze only. On ready with br_taken still 1: pc_src=1 and flushes.
- Timeout: dmem_ready=0 held with WAIT_MAX=8. After 9 cycles of not-ready, state=ERROR and timeout_err=1; all enables stay 0; stall_cnt frozen. Reset low for one edge: state RUN, timeout_err 0, stall_cnt 0.
- Saturation: CNT_W=4, continuous stalls for 20 cycles. Expect stall_cnt to stick at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and parameter defaults for the hazard controller
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int WAIT_MAX_DEF = 8;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use and taken-branch detection
module hazard_detect #(
  parameter int REG_W = pipeline_hazard_ctrl_pkg::REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  output logic             load_use,
  output logic             br_taken
);
  assign load_use = idex_mem_read && idex_rt != '0 && (idex_rt == id_rs || idex_rt == id_rt);
  assign br_taken = exmem_branch && exmem_zero;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with memory-wait FSM, timeout flag and stall counter
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WC_W = $clog2(WAIT_MAX + 1);
  state_t st, nxt;
  logic [WC_W-1:0] wait_cnt, wc_nxt;
  logic to_nxt, load_use, br_taken, mem_wait;
  hazard_detect #(.REG_W(REG_W)) u_hd (
    .id_rs(id_rs),
    .id_rt(id_rt),
    .idex_mem_read(idex_mem_read),
    .idex_rt(idex_rt),
    .exmem_branch(exmem_branch),
    .exmem_zero(exmem_zero),
    .load_use(load_use),
    .br_taken(br_taken)
  );
  assign mem_wait = dmem_req && !dmem_ready;
  assign state = st;
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
    {pc_src, ifid_flush, idex_flush, exmem_flush, memwb_bubble} = '0;
    nxt = st;
    wc_nxt = wait_cnt;
    to_nxt = timeout_err;
    if (!reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_bubble} = '1;
    end else if (st == ERROR) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else if (mem_wait) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_bubble = 1'b1;
      nxt = st == RUN ? MEM_WAIT : wait_cnt == WC_W'(WAIT_MAX) ? ERROR : MEM_WAIT;
      wc_nxt = st == RUN ? WC_W'(1) : wait_cnt == WC_W'(WAIT_MAX) ? wait_cnt : wait_cnt + WC_W'(1);
      to_nxt = timeout_err || (st == MEM_WAIT && wait_cnt == WC_W'(WAIT_MAX));
    end else begin
      nxt = RUN;
      wc_nxt = '0;
      if (br_taken) begin
        pc_src = 1'b1;
        {ifid_flush, idex_flush, exmem_flush} = '1;
      end else if (load_use) begin
        pc_en = 1'b0;
        ifid_en = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= RUN;
      wait_cnt <= '0;
      stall_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      st <= nxt;
      wait_cnt <= wc_nxt;
      timeout_err <= to_nxt;
      if (st != ERROR && !pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule
